// File: rtl/pc_controller_if.sv
// Bundle between the control-flow sequencer and its surroundings: instruction
// fetch handshake, current PC, and the PC-update strobes toward program_counter.
interface pc_controller_if #(
  parameter int ADDR_W = 16,
  parameter int DISP_W = 8
) ();
  logic [15:0]       instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_en;
  logic              pc_mux;
  logic [DISP_W-1:0] disp;
  logic              j_en;
  logic [ADDR_W-1:0] dest;

  modport master (
    input  instr, instr_valid, pc_addr,
    output pc_en, pc_mux, disp, j_en, dest
  );

  modport slave (
    output instr, instr_valid, pc_addr,
    input  pc_en, pc_mux, disp, j_en, dest
  );
endinterface

// File: rtl/pc_controller.sv
// CR16 control-flow sequencer: FETCH/DECODE/EXEC/MEM, one PC update per instruction.
// Optional taken-branch statistics counter enabled by defining PC_CTRL_STATS_EN.
module pc_controller #(
  parameter int ADDR_W = 16,
  parameter int DISP_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  pc_controller_if.master   bus,
  input  logic [4:0]        flags,
  input  logic              mem_done,
  input  logic [ADDR_W-1:0] rtgt_data,
  output logic [3:0]        rtgt_addr,
  output logic [15:0]       ir_q,
  output logic              link_we,
  output logic [3:0]        link_addr,
  output logic [ADDR_W-1:0] link_data,
  output logic              mem_en,
  output logic [15:0]       taken_count
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_MEM    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       ir_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic              is_bcond_s, is_jcond_s, is_jal_s, is_mem_s, cond_s;
  logic              pc_en_s, pc_mux_s, j_en_s, link_we_s, mem_en_s;

  // Flags are {N,Z,F,L,C}; code 4'hF is the never-taken slot.
  function automatic logic cond_eval(input logic [3:0] code, input logic [4:0] f);
    logic n, z, fl, l, c;
    {n, z, fl, l, c} = f;
    case (code)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = ~z;
      4'h2:    cond_eval = c;
      4'h3:    cond_eval = ~c;
      4'h4:    cond_eval = l;
      4'h5:    cond_eval = ~l;
      4'h6:    cond_eval = n;
      4'h7:    cond_eval = ~n;
      4'h8:    cond_eval = fl;
      4'h9:    cond_eval = ~fl;
      4'hA:    cond_eval = ~l & ~z;
      4'hB:    cond_eval = l | z;
      4'hC:    cond_eval = ~n & ~z;
      4'hD:    cond_eval = n | z;
      4'hE:    cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign is_bcond_s = (ir_q[15:12] == 4'hC);
  assign is_jcond_s = (ir_q[15:12] == 4'h4) && (ir_q[7:4] == 4'hC);
  assign is_jal_s   = (ir_q[15:12] == 4'h4) && (ir_q[7:4] == 4'h8);
  assign is_mem_s   = (ir_q[15:12] == 4'h4) && ((ir_q[7:4] == 4'h0) || (ir_q[7:4] == 4'h4));
  assign cond_s     = cond_eval(ir_q[11:8], flags);

  // Next-state, IR/dest capture and the single-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    dest_d    = dest_q;
    pc_en_s   = 1'b0;
    pc_mux_s  = 1'b0;
    j_en_s    = 1'b0;
    link_we_s = 1'b0;
    mem_en_s  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        dest_d  = rtgt_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (is_bcond_s) begin
          pc_en_s  = 1'b1;
          pc_mux_s = cond_s;
        end else if (is_jcond_s) begin
          if (cond_s) begin
            j_en_s = 1'b1;
          end else begin
            pc_en_s = 1'b1;
          end
        end else if (is_jal_s) begin
          j_en_s    = 1'b1;
          link_we_s = 1'b1;
        end else if (is_mem_s) begin
          state_d = S_MEM;
        end else begin
          pc_en_s = 1'b1;
        end
      end
      S_MEM: begin
        mem_en_s = 1'b1;
        if (mem_done) begin
          pc_en_s = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State, instruction register and latched jump target.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ir_q    <= 16'd0;
      dest_q  <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      dest_q  <= dest_d;
    end
  end

  assign bus.pc_en  = pc_en_s;
  assign bus.pc_mux = pc_mux_s;
  assign bus.j_en   = j_en_s;
  assign bus.disp   = ir_q[DISP_W-1:0];
  assign bus.dest   = dest_q;
  assign link_we    = link_we_s;
  assign mem_en     = mem_en_s;
  assign rtgt_addr  = ir_q[3:0];
  assign link_addr  = ir_q[11:8];
  assign link_data  = bus.pc_addr + ADDR_W'(1);

`ifdef PC_CTRL_STATS_EN
  logic        taken_s;
  logic [15:0] taken_count_q, taken_count_d;

  assign taken_s = (state_q == S_EXEC) &&
                   (((is_bcond_s || is_jcond_s) && cond_s) || is_jal_s);

  // Wrapping count of taken branches, taken jumps and JALs.
  always_comb begin
    if (taken_s) begin
      taken_count_d = taken_count_q + 16'd1;
    end else begin
      taken_count_d = taken_count_q;
    end
  end

  // Statistics register, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      taken_count_q <= 16'd0;
    end else begin
      taken_count_q <= taken_count_d;
    end
  end

  assign taken_count = taken_count_q;
`else
  assign taken_count = 16'd0;
`endif

endmodule

// File: tb/tb_pc_controller.sv
// Directed bench for pc_controller: a per-cycle expectation model plus literal spot checks.
module tb_pc_controller;
  logic        clock;
  logic        reset;
  logic [4:0]  flags;
  logic        mem_done;
  logic [15:0] rtgt_data;
  logic [3:0]  rtgt_addr;
  logic [15:0] ir_q;
  logic        link_we;
  logic [3:0]  link_addr;
  logic [15:0] link_data;
  logic        mem_en;
  logic [15:0] taken_count;

  pc_controller_if #(.ADDR_W(16), .DISP_W(8)) bus_if ();

  pc_controller #(.ADDR_W(16), .DISP_W(8)) dut (
    .clock(clock), .reset(reset), .bus(bus_if), .flags(flags), .mem_done(mem_done),
    .rtgt_data(rtgt_data), .rtgt_addr(rtgt_addr), .ir_q(ir_q), .link_we(link_we),
    .link_addr(link_addr), .link_data(link_data), .mem_en(mem_en), .taken_count(taken_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad = 0;

  // expected per-cycle outputs; exp_vec = {pc_en, pc_mux, j_en, link_we, mem_en}
  logic [4:0]  exp_vec, exp_exec_vec;
  logic [15:0] exp_ir, exp_dest, exp_link_data, exp_count;
  logic [7:0]  exp_disp;
  logic [3:0]  exp_link_addr;
  bit          chk_en, chk_ir, chk_data, exp_mem_cls, exp_taken_ev;
  int          mcyc;

  // Condition truth from the flag rules: pairs share a base, odd code inverts it.
  function automatic logic cond_model(input logic [3:0] c, input logic [4:0] f);
    logic n, z, ff, l, cy, base;
    {n, z, ff, l, cy} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = l;
      3'd3:    base = n;
      3'd4:    base = ff;
      3'd5:    base = !(l || z);
      3'd6:    base = !(n || z);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic compare_cycle();
    check_lit("strobes", {bus_if.pc_en, bus_if.pc_mux, bus_if.j_en, link_we, mem_en}, exp_vec);
    check_lit("taken_count", taken_count, exp_count);
    if (chk_ir) begin
      check_lit("ir_q", ir_q, exp_ir);
      check_lit("rtgt_addr", rtgt_addr, exp_ir[3:0]);
    end
    if (chk_data) begin
      check_lit("dest", bus_if.dest, exp_dest);
      check_lit("disp", bus_if.disp, exp_disp);
      check_lit("link_addr", link_addr, exp_link_addr);
      check_lit("link_data", link_data, exp_link_data);
    end
  endtask

  // Compare the current cycle at the falling edge, then advance to just past the next rising edge.
  task automatic step();
    @(negedge clock);
    if (chk_en) compare_cycle();
    @(posedge clock);
    #1;
  endtask

  // Drive one instruction through FETCH and DECODE; returns inside the EXEC cycle.
  task automatic start_instr(input logic [15:0] ins, input logic [4:0] fl,
                             input logic [15:0] rt, input logic [15:0] pc);
    logic t;
    logic [3:0] top, mid;
    t = cond_model(ins[11:8], fl);
    top = ins[15:12];
    mid = ins[7:4];
    exp_mem_cls = 1'b0;
    exp_taken_ev = 1'b0;
    if (top == 4'hC) begin
      exp_exec_vec = {1'b1, t, 3'b000};
      exp_taken_ev = t;
    end else if (top == 4'h4 && mid == 4'hC) begin
      exp_exec_vec = t ? 5'b00100 : 5'b10000;
      exp_taken_ev = t;
    end else if (top == 4'h4 && mid == 4'h8) begin
      exp_exec_vec = 5'b00110;
      exp_taken_ev = 1'b1;
    end else if (top == 4'h4 && (mid == 4'h0 || mid == 4'h4)) begin
      exp_exec_vec = 5'b00000;
      exp_mem_cls = 1'b1;
    end else begin
      exp_exec_vec = 5'b10000;
    end
    chk_en = 1'b1;
    chk_data = 1'b0;
    exp_vec = 5'b00000;
    bus_if.instr = ins;
    bus_if.instr_valid = 1'b1;
    bus_if.pc_addr = pc;
    flags = ~fl;
    rtgt_data = ~rt;
    mem_done = 1'b0;
    step();
    // DECODE: a new word with instr_valid still high must be ignored
    bus_if.instr = ~ins;
    rtgt_data = rt;
    chk_ir = 1'b1;
    exp_ir = ins;
    step();
    // EXEC: flags only now valid, rtgt_data no longer
    flags = fl;
    rtgt_data = ~rt;
    exp_vec = exp_exec_vec;
    chk_data = 1'b1;
    exp_dest = rt;
    exp_disp = ins[7:0];
    exp_link_addr = ins[11:8];
    exp_link_data = pc + 16'd1;
    #1;
  endtask

  task automatic finish_instr(input int lat, output int mem_cycles);
    mem_cycles = 0;
    if (exp_mem_cls) begin
      step();
      for (int k = 1; k <= lat; k++) begin
        mem_done = (k == lat);
        exp_vec = {(k == lat), 4'b0001};
        #1;
        if (mem_en === 1'b1) mem_cycles++;
        step();
      end
      mem_done = 1'b0;
    end else begin
      step();
    end
    bus_if.instr_valid = 1'b0;
`ifdef PC_CTRL_STATS_EN
    if (exp_taken_ev) exp_count = exp_count + 16'd1;
`endif
    exp_vec = 5'b00000;
  endtask

  task automatic run(input logic [15:0] ins, input logic [4:0] fl,
                     input logic [15:0] rt, input logic [15:0] pc);
    int m;
    start_instr(ins, fl, rt, pc);
    finish_instr(2, m);
  endtask

  initial begin
    reset = 1'b0;
    flags = 5'd0;
    mem_done = 1'b0;
    rtgt_data = 16'd0;
    bus_if.instr = 16'd0;
    bus_if.instr_valid = 1'b0;
    bus_if.pc_addr = 16'd0;
    chk_en = 1'b0; chk_ir = 1'b0; chk_data = 1'b0;
    exp_vec = 5'd0; exp_count = 16'd0; exp_ir = 16'd0;
    #3;
    check_lit("rst_ir_q", ir_q, 16'h0000);
    check_lit("rst_dest", bus_if.dest, 16'h0000);
    check_lit("rst_strobes", {bus_if.pc_en, bus_if.j_en, link_we, mem_en}, 4'b0000);
    check_lit("rst_taken_count", taken_count, 16'h0000);
    step();
    step();
    reset = 1'b1;
    chk_en = 1'b1;
    step();

    // BEQ disp=FE, Z=1: taken
    start_instr(16'hC0FE, 5'b01000, 16'h0000, 16'h0020);
    check_lit("beq_t_pc_en", bus_if.pc_en, 1'b1);
    check_lit("beq_t_pc_mux", bus_if.pc_mux, 1'b1);
    check_lit("beq_t_disp", bus_if.disp, 8'hFE);
    check_lit("beq_t_j_en", bus_if.j_en, 1'b0);
    finish_instr(0, mcyc);
    // BEQ, Z=0: not taken
    start_instr(16'hC0FE, 5'b00000, 16'h0000, 16'h0021);
    check_lit("beq_nt_pc_en", bus_if.pc_en, 1'b1);
    check_lit("beq_nt_pc_mux", bus_if.pc_mux, 1'b0);
    finish_instr(0, mcyc);
    // cond F never taken, all flags set
    start_instr(16'hCF10, 5'b11111, 16'h0000, 16'h0022);
    check_lit("bnever_pc_en", bus_if.pc_en, 1'b1);
    check_lit("bnever_pc_mux", bus_if.pc_mux, 1'b0);
    finish_instr(0, mcyc);
    // JAL R3,R5
    start_instr(16'h4385, 5'b00000, 16'h0040, 16'h0010);
    check_lit("jal_j_en", bus_if.j_en, 1'b1);
    check_lit("jal_dest", bus_if.dest, 16'h0040);
    check_lit("jal_link_we", link_we, 1'b1);
    check_lit("jal_link_addr", link_addr, 4'h3);
    check_lit("jal_link_data", link_data, 16'h0011);
    check_lit("jal_pc_en", bus_if.pc_en, 1'b0);
    check_lit("jal_rtgt_addr", rtgt_addr, 4'h5);
    finish_instr(0, mcyc);
    // JAL link wrap
    start_instr(16'h4A81, 5'b00000, 16'h1234, 16'hFFFF);
    check_lit("jal_wrap_link_data", link_data, 16'h0000);
    finish_instr(0, mcyc);
    // LOAD with mem_done on the third MEM cycle
    start_instr(16'h4102, 5'b00000, 16'h0000, 16'h0030);
    check_lit("load_exec_pc_en", bus_if.pc_en, 1'b0);
    finish_instr(3, mcyc);
    check_lit("load_mem_cycles", mcyc, 3);
    check_lit("load_after_mem_en", mem_en, 1'b0);
    // STOR, single MEM cycle
    start_instr(16'h4247, 5'b00000, 16'h0000, 16'h0031);
    finish_instr(1, mcyc);
    check_lit("stor_mem_cycles", mcyc, 1);
    // Misc: non-control op, Jcond not taken, Jcond never, other 4xxx op
    run(16'h1234, 5'b10101, 16'h0000, 16'h0040);
    run(16'h40C3, 5'b00000, 16'hAAAA, 16'h0041);
    run(16'h4FC3, 5'b11111, 16'hAAAA, 16'h0042);
    run(16'h4123, 5'b01010, 16'h0000, 16'h0043);

    // All conditions against all flag combinations, as Bcond and Jcond
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 32; f++) begin
        run({4'hC, c[3:0], 8'h10}, f[4:0], 16'h1234, 16'h0100);
        run({4'h4, c[3:0], 4'hC, 4'h2}, f[4:0], 16'h5678, 16'h0200);
      end
    end

    // Reset during EXEC of a taken JUC
    start_instr(16'h4EC7, 5'b00000, 16'hBEEF, 16'h0300);
    check_lit("juc_j_en", bus_if.j_en, 1'b1);
    chk_en = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_lit("rst_mid_j_en", bus_if.j_en, 1'b0);
    check_lit("rst_mid_pc_en", bus_if.pc_en, 1'b0);
    check_lit("rst_mid_link_we", link_we, 1'b0);
    check_lit("rst_mid_ir_q", ir_q, 16'h0000);
    check_lit("rst_mid_dest", bus_if.dest, 16'h0000);
    check_lit("rst_mid_taken_count", taken_count, 16'h0000);
    step();
    reset = 1'b1;
    bus_if.instr_valid = 1'b0;
    exp_count = 16'd0;
    exp_vec = 5'd0;
    chk_ir = 1'b0;
    chk_data = 1'b0;
    chk_en = 1'b1;
    step();

    // Resume at FETCH, then 3 taken + 2 not-taken in total
    run(16'h4EC7, 5'b00000, 16'hBEEF, 16'h0300);
    run(16'hC0FE, 5'b01000, 16'h0000, 16'h0301);
    run(16'hCE10, 5'b00000, 16'h0000, 16'h0302);
    run(16'hC1FE, 5'b01000, 16'h0000, 16'h0303);
    run(16'hCF10, 5'b00000, 16'h0000, 16'h0304);
`ifdef PC_CTRL_STATS_EN
    check_lit("stats_taken_count", taken_count, 16'd3);
`else
    check_lit("stats_taken_count", taken_count, 16'd0);
`endif
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
